// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
//   ST_IDLE..ST_STOP : frame FSM state encoding
//   MID_START_TICK   : s_tick count that lands in the middle of the start bit
//   LAST_BIT_TICK    : s_tick count that ends one 16x-oversampled bit period
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [3:0] MID_START_TICK = 4'd7;
    localparam logic [3:0] LAST_BIT_TICK  = 4'd15;

endpackage

// File: rtl/uart_receiver_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset
// to 1 so that reset looks like an idle (high) line.
//   clk, reset_n : system clock, async active-low reset
//   d            : asynchronous input
//   q            : synchronized output, lags d by 2 clk
module rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver with 16x oversampling: detects the start edge, samples
// each data bit in its middle (LSB first), checks the stop bit.
//   clk, reset_n  : system clock, async active-low reset
//   s_tick        : one-clk strobe at 16x baud
//   rx            : serial line (asynchronous, idle high)
//   rx_dout       : last received word, held until the next rx_done_tick
//   rx_done_tick  : one-clk pulse when a frame completes
//   frame_err     : valid with rx_done_tick; high when the stop bit was low
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned dbits   = 8,
    parameter int unsigned sb_tick = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_tick,
    input  logic             rx,
    output logic [dbits-1:0] rx_dout,
    output logic             rx_done_tick,
    output logic             frame_err
);

    // Tick counter is 4 bits for the data phase, widened so the stop
    // phase can count up to sb_tick-1 (e.g. 31 for two stop bits).
    localparam int unsigned SW = (sb_tick > 16) ? $clog2(sb_tick) : 4;
    localparam int unsigned NW = (dbits > 1) ? $clog2(dbits) : 1;

    logic             rx_s;
    logic [1:0]       state, state_next;
    logic [SW-1:0]    s, s_next;
    logic [NW-1:0]    n, n_next;
    logic [dbits-1:0] b, b_next;
    logic [dbits-1:0] rx_dout_next;
    logic             rx_done_tick_next;
    logic             frame_err_next;

    rx_sync u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            rx_dout      <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            b            <= b_next;
            rx_dout      <= rx_dout_next;
            rx_done_tick <= rx_done_tick_next;
            frame_err    <= frame_err_next;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_next        = state;
        s_next            = s;
        n_next            = n;
        b_next            = b;
        rx_dout_next      = rx_dout;
        rx_done_tick_next = 1'b0;
        frame_err_next    = 1'b0;

        case (state)
            ST_IDLE: begin
                // Start detect is edge-driven, not gated by s_tick
                if (!rx_s) begin
                    s_next     = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s == SW'(MID_START_TICK)) begin
                        if (!rx_s) begin
                            s_next     = '0;
                            n_next     = '0;
                            state_next = ST_DATA;
                        end else begin
                            // Line back high mid start bit: glitch
                            state_next = ST_IDLE;
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s == SW'(LAST_BIT_TICK)) begin
                        s_next = '0;
                        b_next = {rx_s, b[dbits-1:1]};
                        if (n == NW'(dbits - 1)) begin
                            state_next = ST_STOP;
                        end else begin
                            n_next = n + NW'(1);
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s == SW'(sb_tick - 1)) begin
                        rx_done_tick_next = 1'b1;
                        frame_err_next    = ~rx_s;
                        rx_dout_next      = b;
                        state_next        = ST_IDLE;
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
